// File: rtl/dma_pkg.sv
// Shared definitions for the DMA transfer engine: FSM states, control-register
// bit positions and register-map offsets.
package dma_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } dma_state_e;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_INC_SRC  = 2;
    localparam int unsigned CTRL_INC_DSTN = 3;

    localparam logic [7:0] REG_SRC_OFS   = 8'h00;
    localparam logic [7:0] REG_COUNT_OFS = 8'h04;
    localparam logic [7:0] REG_CTRL_OFS  = 8'h08;
    localparam logic [7:0] REG_DSTN_OFS  = 8'h0C;

    // True in the states that own the memory bus.
    function automatic logic is_bus_state(input dma_state_e st);
        return (st == ST_RD) || (st == ST_WR);
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// Loadable address counter: loads a start address, optionally steps by one
// word per completed write, and wraps naturally modulo 2^ADDR_W.
module dma_addr_gen
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc_en,
    output logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] addr_nxt
);

    logic [ADDR_W-1:0] addr_r;

    // Next address: load has priority over increment.
    always_comb begin
        addr_nxt = addr_r;
        if (load) begin
            addr_nxt = load_addr;
        end else if (inc_en) begin
            addr_nxt = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else begin
            addr_nxt = addr_r;
        end
    end

    // Address register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r <= {ADDR_W{1'b0}};
        end else begin
            addr_r <= addr_nxt;
        end
    end

    assign addr = addr_r;

endmodule

// File: rtl/dma_transfer_engine.sv
// Single-channel word-by-word DMA engine (read one word, write one word).
// Optional interrupt output is compiled in when DMA_IRQ_EN is defined.
module dma_transfer_engine
    import dma_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ctrl_sig_reg,
    input  logic [31:0]       src_addr_reg,
    input  logic [31:0]       dstn_addr_reg,
    input  logic [31:0]       count_reg,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
`ifdef DMA_IRQ_EN
    output logic              irq,
    input  logic              irq_clr,
`endif
    output logic [31:0]       words_left
);

    dma_state_e        state_r;
    dma_state_e        state_nxt_s;
    logic              en_s;
    logic              en_prev_r;
    logic              start_s;
    logic              abort_r;
    logic              abort_s;
    logic              rd_ack_s;
    logic              wr_ack_s;
    logic              inc_src_r;
    logic              inc_dstn_r;
    logic [31:0]       words_left_r;
    logic [DATA_W-1:0] data_buf_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] mem_addr_nxt_s;
    logic              busy_r;
    logic              done_r;
    logic [ADDR_W-1:0] src_addr_s;
    logic [ADDR_W-1:0] src_nxt_s;
    logic [ADDR_W-1:0] dstn_addr_s;
    logic [ADDR_W-1:0] dstn_nxt_s;
    logic              unused_ctrl_s;

    assign unused_ctrl_s = ^{ctrl_sig_reg[31:4], ctrl_sig_reg[1], src_addr_s, dstn_addr_s};

    assign en_s     = ctrl_sig_reg[CTRL_EN];
    assign start_s  = (state_r == ST_IDLE) && en_s && !en_prev_r;
    // Abort is sticky once seen so a re-raised enable cannot cancel it.
    assign abort_s  = abort_r || !en_s;
    assign rd_ack_s = (state_r == ST_RD) && mem_ack;
    assign wr_ack_s = (state_r == ST_WR) && mem_ack;

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_src_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (start_s),
        .load_addr (src_addr_reg[ADDR_W-1:0]),
        .inc_en    (wr_ack_s && inc_src_r),
        .addr      (src_addr_s),
        .addr_nxt  (src_nxt_s)
    );

    dma_addr_gen #(.ADDR_W(ADDR_W)) u_dstn_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (start_s),
        .load_addr (dstn_addr_reg[ADDR_W-1:0]),
        .inc_en    (wr_ack_s && inc_dstn_r),
        .addr      (dstn_addr_s),
        .addr_nxt  (dstn_nxt_s)
    );

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = (count_reg == 32'd0) ? ST_DONE : ST_RD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    state_nxt_s = abort_s ? ST_IDLE : ST_WR;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_WR: begin
                if (!mem_ack) begin
                    state_nxt_s = ST_WR;
                end else if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (words_left_r <= 32'd1) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Bus address for the phase being entered; held otherwise.
    always_comb begin
        mem_addr_nxt_s = mem_addr_r;
        if (state_nxt_s == ST_RD) begin
            mem_addr_nxt_s = src_nxt_s;
        end else if (state_nxt_s == ST_WR) begin
            mem_addr_nxt_s = dstn_nxt_s;
        end else begin
            mem_addr_nxt_s = mem_addr_r;
        end
    end

    // State, edge detect and registered bus/status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            en_prev_r  <= 1'b0;
            abort_r    <= 1'b0;
            mem_req_r  <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_addr_r <= {ADDR_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            en_prev_r  <= en_s;
            abort_r    <= is_bus_state(state_nxt_s) && abort_s;
            mem_req_r  <= is_bus_state(state_nxt_s);
            mem_we_r   <= (state_nxt_s == ST_WR);
            mem_addr_r <= mem_addr_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            done_r     <= (state_nxt_s == ST_DONE);
        end
    end

    // Latched transfer configuration and remaining word count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inc_src_r    <= 1'b0;
            inc_dstn_r   <= 1'b0;
            words_left_r <= 32'd0;
        end else if (start_s) begin
            inc_src_r    <= ctrl_sig_reg[CTRL_INC_SRC];
            inc_dstn_r   <= ctrl_sig_reg[CTRL_INC_DSTN];
            words_left_r <= count_reg;
        end else if (wr_ack_s) begin
            words_left_r <= words_left_r - 32'd1;
        end else begin
            words_left_r <= words_left_r;
        end
    end

    // One-word data buffer, doubling as the write-data driver.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_buf_r <= {DATA_W{1'b0}};
        end else if (rd_ack_s) begin
            data_buf_r <= mem_rdata;
        end else begin
            data_buf_r <= data_buf_r;
        end
    end

`ifdef DMA_IRQ_EN
    logic irq_r;

    // Interrupt flag: set in DONE wins over clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            irq_r <= 1'b1;
        end else if (irq_clr || start_s) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= irq_r;
        end
    end

    assign irq = irq_r;
`endif

    assign mem_req    = mem_req_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = data_buf_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign words_left = words_left_r;

endmodule

// File: tb/tb_dma_transfer_engine.sv
// Scoreboard bench for dma_transfer_engine: expected bus transactions are queued
// at transfer start and checked by a memory responder on every ack.
module tb_dma_transfer_engine;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       ctrl_sig_reg;
    logic [31:0]       src_addr_reg;
    logic [31:0]       dstn_addr_reg;
    logic [31:0]       count_reg;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              busy;
    logic              done;
    logic [31:0]       words_left;
`ifdef DMA_IRQ_EN
    logic              irq;
    logic              irq_clr;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_exp_t;

    bus_exp_t sb_q[$];
    int vectors      = 0;
    int miscompares  = 0;
    int ack_dly      = 0;
    int writes_acked = 0;
    int req_cycles   = 0;

    always #5 clk = ~clk;

    dma_transfer_engine #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .ctrl_sig_reg  (ctrl_sig_reg),
        .src_addr_reg  (src_addr_reg),
        .dstn_addr_reg (dstn_addr_reg),
        .count_reg     (count_reg),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .busy          (busy),
        .done          (done),
`ifdef DMA_IRQ_EN
        .irq           (irq),
        .irq_clr       (irq_clr),
`endif
        .words_left    (words_left)
    );

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a * 32'h0001_0003) ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder: acks after ack_dly wait cycles and checks against the scoreboard.
    initial begin
        int       wait_cnt;
        bus_exp_t e;
        mem_ack  = 1'b0;
        mem_rdata = 32'd0;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!mem_req) begin
                wait_cnt = 0;
            end else begin
                req_cycles++;
                if (wait_cnt < ack_dly) begin
                    wait_cnt++;
                end else begin
                    wait_cnt = 0;
                    if (sb_q.size() == 0) begin
                        check_eq("sb_pending", 32'(sb_q.size()), 32'd1);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("bus_we", {31'd0, mem_we}, {31'd0, e.we});
                        check_eq("bus_addr", mem_addr, e.addr);
                        if (e.we) begin
                            check_eq("bus_wdata", mem_wdata, e.data);
                            writes_acked++;
                        end
                    end
                    mem_rdata = mem_model(mem_addr);
                    mem_ack   = 1'b1;
                end
            end
        end
    end

    task automatic push_xfer(input logic [31:0] src, input logic [31:0] dst, input int n,
                             input logic inc_s, input logic inc_d);
        for (int i = 0; i < n; i++) begin
            logic [31:0] ra;
            logic [31:0] wa;
            ra = src + (inc_s ? 32'(i) : 32'd0);
            wa = dst + (inc_d ? 32'(i) : 32'd0);
            sb_q.push_back('{we: 1'b0, addr: ra, data: 32'd0});
            sb_q.push_back('{we: 1'b1, addr: wa, data: mem_model(ra)});
        end
    endtask

    // Returns at the falling edge of the cycle after the start edge was sampled.
    task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst,
                              input logic [31:0] cnt, input logic [31:0] ctrl);
        @(negedge clk);
        ctrl_sig_reg = 32'd0;
        @(negedge clk);
        src_addr_reg  = src;
        dstn_addr_reg = dst;
        count_reg     = cnt;
        ctrl_sig_reg  = ctrl;
        @(negedge clk);
        check_eq("req_latency", {31'd0, mem_req}, {31'd0, (cnt != 32'd0)});
        src_addr_reg  = 32'hDEAD_0000;
        dstn_addr_reg = 32'hBEEF_0000;
        count_reg     = 32'd77;
        ctrl_sig_reg  = ctrl & 32'h1;
    endtask

    task automatic wait_done(input int max, output int k);
        k = 1;
        while (!done && k < max) begin
            @(negedge clk);
            k++;
        end
        check_eq("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic finish_checks(input int k, input int exp_k);
        check_eq("done_cycle", 32'(k), 32'(exp_k));
        check_eq("done_busy", {31'd0, busy}, 32'd1);
        check_eq("done_words_left", words_left, 32'd0);
        @(negedge clk);
        check_eq("done_pulse", {31'd0, done}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        int n;
        int rc;
        int wa0;
        logic done_seen;

        reset         = 1'b0;
        ctrl_sig_reg  = 32'd0;
        src_addr_reg  = 32'd0;
        dstn_addr_reg = 32'd0;
        count_reg     = 32'd0;
`ifdef DMA_IRQ_EN
        irq_clr       = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_eq("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_words_left", words_left, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Incrementing copy, zero-wait memory.
        ack_dly = 0;
        push_xfer(32'h100, 32'h200, 3, 1'b1, 1'b1);
        start_xfer(32'h100, 32'h200, 32'd3, 32'hD);
        wait_done(60, k);
`ifdef DMA_IRQ_EN
        finish_checks(k, 7);
        check_eq("irq_set", {31'd0, irq}, 32'd1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check_eq("irq_clr", {31'd0, irq}, 32'd0);
`else
        finish_checks(k, 7);
`endif

        // Fixed source address, one wait state.
        ack_dly = 1;
        push_xfer(32'h40, 32'h300, 4, 1'b0, 1'b1);
        start_xfer(32'h40, 32'h300, 32'd4, 32'h9);
        wait_done(100, k);
        finish_checks(k, 17);

        // Zero count: no bus activity.
        ack_dly = 0;
        rc = req_cycles;
        start_xfer(32'h500, 32'h600, 32'd0, 32'h1);
        wait_done(20, k);
        finish_checks(k, 1);
        check_eq("zero_count_no_req", 32'(req_cycles), 32'(rc));

        // Destination wraps to address 0.
        ack_dly = 2;
        push_xfer(32'h10, 32'hFFFF_FFFF, 2, 1'b1, 1'b1);
        start_xfer(32'h10, 32'hFFFF_FFFF, 32'd2, 32'hD);
        wait_done(100, k);
        finish_checks(k, 13);

        // Abort during the second write with a slow memory.
        ack_dly = 3;
        wa0 = writes_acked;
        push_xfer(32'h800, 32'h900, 2, 1'b1, 1'b1);
        start_xfer(32'h800, 32'h900, 32'd5, 32'hD);
        n = 0;
        while (!(writes_acked == wa0 + 1 && mem_req && mem_we && !mem_ack) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_eq("abort_window", {31'd0, (n < 200)}, 32'd1);
        ctrl_sig_reg = 32'hC;
        n = 0;
        done_seen = 1'b0;
        while (busy && n < 100) begin
            @(negedge clk);
            #1;
            if (done) done_seen = 1'b1;
            n++;
        end
        check_eq("abort_idle", {31'd0, busy}, 32'd0);
        check_eq("abort_no_done", {31'd0, done_seen}, 32'd0);
        check_eq("abort_words_left", words_left, 32'd3);
        check_eq("abort_req_dropped", {31'd0, mem_req}, 32'd0);
        check_eq("abort_sb_drained", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of a bus request.
        ack_dly = 3;
        push_xfer(32'h20, 32'h30, 2, 1'b1, 1'b1);
        start_xfer(32'h20, 32'h30, 32'd2, 32'hD);
        check_eq("pre_rst_req", {31'd0, mem_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_req", {31'd0, mem_req}, 32'd0);
        check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("async_rst_words_left", words_left, 32'd0);
        sb_q.delete();

        // Enable already high at reset release counts as a start edge.
        @(negedge clk);
        count_reg    = 32'd0;
        ctrl_sig_reg = 32'h1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("release_start_done", {31'd0, done}, 32'd1);
        check_eq("release_start_no_req", {31'd0, mem_req}, 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
